// File: rtl/pe_os_seq_if.sv
// Bundle of control, operand, forwarding and result signals for one output-stationary PE.
// The master side drives jobs, operands and out_ready_i; the slave side is the PE.
interface pe_os_seq_if #(
    parameter int IFMAP_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 8,
    parameter int K_MAX        = 64,
    parameter int OUT_WIDTH    = 8,
    parameter int ACC_WIDTH    = IFMAP_WIDTH + WEIGHT_WIDTH + $clog2(K_MAX) + 1,
    parameter int KLEN_W       = $clog2(K_MAX + 1)
);
    logic                           en;
    logic                           start;
    logic [KLEN_W-1:0]              k_len;
    logic [1:0]                     act_mode;
    logic [4:0]                     out_shift;
    logic signed [IFMAP_WIDTH-1:0]  ifmap_i;
    logic                           ifmap_v_i;
    logic signed [WEIGHT_WIDTH-1:0] weight_i;
    logic                           weight_v_i;
    logic signed [BIAS_WIDTH-1:0]   bias_i;
    logic signed [IFMAP_WIDTH-1:0]  ifmap_o;
    logic                           ifmap_v_o;
    logic signed [WEIGHT_WIDTH-1:0] weight_o;
    logic                           weight_v_o;
    logic signed [OUT_WIDTH-1:0]    out_o;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic signed [ACC_WIDTH-1:0]    psum_o;
    logic                           busy_o;

    modport master (
        output en, start, k_len, act_mode, out_shift,
        output ifmap_i, ifmap_v_i, weight_i, weight_v_i, bias_i, out_ready_i,
        input  ifmap_o, ifmap_v_o, weight_o, weight_v_o, out_o, out_valid_o, psum_o, busy_o
    );

    modport slave (
        input  en, start, k_len, act_mode, out_shift,
        input  ifmap_i, ifmap_v_i, weight_i, weight_v_i, bias_i, out_ready_i,
        output ifmap_o, ifmap_v_o, weight_o, weight_v_o, out_o, out_valid_o, psum_o, busy_o
    );
endinterface

// File: rtl/pe_os_seq.sv
// Output-stationary MAC processing element with its own job sequencer.
// Accumulates k_len operand beats, adds shifted bias, activates, requantises and saturates.
module pe_os_seq #(
    parameter int IFMAP_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 8,
    parameter int K_MAX        = 64,
    parameter int BIAS_SHIFT   = 7,
    parameter int OUT_WIDTH    = 8
) (
    input logic           clk,
    input logic           nrst,
    pe_os_seq_if.slave    bus
);
    localparam int ACC_WIDTH = IFMAP_WIDTH + WEIGHT_WIDTH + $clog2(K_MAX) + 1;
    localparam int KLEN_W    = $clog2(K_MAX + 1);
    localparam int PROD_W    = IFMAP_WIDTH + WEIGHT_WIDTH;

    localparam logic [KLEN_W-1:0] K_ZERO = {KLEN_W{1'b0}};
    localparam logic [KLEN_W-1:0] K_ONE  = {{(KLEN_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_BIAS = 3'd2,
        S_ACT  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t                          state_r;
    logic [KLEN_W-1:0]               k_len_r;
    logic [KLEN_W-1:0]               count_r;
    logic [1:0]                      act_mode_r;
    logic [4:0]                      out_shift_r;
    logic signed [ACC_WIDTH-1:0]     acc_r;
    logic signed [OUT_WIDTH-1:0]     out_r;
    logic                            out_valid_r;
    logic                            busy_r;
    logic signed [IFMAP_WIDTH-1:0]   ifmap_fwd_r;
    logic signed [WEIGHT_WIDTH-1:0]  weight_fwd_r;
    logic                            fwd_v_r;

    logic                            beat_s;
    logic signed [PROD_W-1:0]        prod_s;
    logic signed [ACC_WIDTH-1:0]     prod_ext_s;
    logic signed [ACC_WIDTH-1:0]     bias_ext_s;
    logic signed [ACC_WIDTH-1:0]     act_s;
    logic signed [ACC_WIDTH-1:0]     shifted_s;
    logic signed [OUT_WIDTH-1:0]     sat_s;

    function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[OUT_WIDTH-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[OUT_WIDTH-1:0];
        end else begin
            return v[OUT_WIDTH-1:0];
        end
    endfunction

    // Datapath: beat detect, sign-extended product and bias, activation, requantise and clamp.
    always_comb begin
        beat_s     = bus.ifmap_v_i & bus.weight_v_i & bus.en;
        prod_s     = bus.ifmap_i * bus.weight_i;
        prod_ext_s = {{(ACC_WIDTH-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        bias_ext_s = {{(ACC_WIDTH-BIAS_WIDTH){bus.bias_i[BIAS_WIDTH-1]}}, bus.bias_i} <<< BIAS_SHIFT;
        act_s      = acc_r;
        case (act_mode_r)
            2'b01: begin
                if (acc_r[ACC_WIDTH-1]) begin
                    act_s = ACC_ZERO;
                end else begin
                    act_s = acc_r;
                end
            end
            2'b10: begin
                if (acc_r[ACC_WIDTH-1]) begin
                    act_s = acc_r >>> 3'd3;
                end else begin
                    act_s = acc_r;
                end
            end
            default: act_s = acc_r;
        endcase
        shifted_s = act_s >>> out_shift_r;
        sat_s     = sat_out(shifted_s);
    end

    // Operand forwarding to east/south neighbours; independent of the job sequencer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ifmap_fwd_r  <= {IFMAP_WIDTH{1'b0}};
            weight_fwd_r <= {WEIGHT_WIDTH{1'b0}};
            fwd_v_r      <= 1'b0;
        end else if (beat_s) begin
            ifmap_fwd_r  <= bus.ifmap_i;
            weight_fwd_r <= bus.weight_i;
            fwd_v_r      <= 1'b1;
        end else begin
            ifmap_fwd_r  <= {IFMAP_WIDTH{1'b0}};
            weight_fwd_r <= {WEIGHT_WIDTH{1'b0}};
            fwd_v_r      <= 1'b0;
        end
    end

    // Job sequencer; en low behaves like a synchronous reset and aborts any job.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= S_IDLE;
            k_len_r     <= K_ZERO;
            count_r     <= K_ZERO;
            act_mode_r  <= 2'b00;
            out_shift_r <= 5'd0;
            acc_r       <= ACC_ZERO;
            out_r       <= {OUT_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (!bus.en) begin
            state_r     <= S_IDLE;
            k_len_r     <= K_ZERO;
            count_r     <= K_ZERO;
            act_mode_r  <= 2'b00;
            out_shift_r <= 5'd0;
            acc_r       <= ACC_ZERO;
            out_r       <= {OUT_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        k_len_r     <= bus.k_len;
                        act_mode_r  <= bus.act_mode;
                        out_shift_r <= bus.out_shift;
                        acc_r       <= ACC_ZERO;
                        count_r     <= K_ZERO;
                        busy_r      <= 1'b1;
                        state_r     <= (bus.k_len == K_ZERO) ? S_BIAS : S_MAC;
                    end
                end
                S_MAC: begin
                    if (beat_s) begin
                        acc_r   <= acc_r + prod_ext_s;
                        count_r <= count_r + K_ONE;
                        if ((count_r + K_ONE) == k_len_r) begin
                            state_r <= S_BIAS;
                        end
                    end
                end
                S_BIAS: begin
                    acc_r   <= acc_r + bias_ext_s;
                    state_r <= S_ACT;
                end
                S_ACT: begin
                    out_r       <= sat_s;
                    out_valid_r <= 1'b1;
                    state_r     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready_i) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ifmap_o     = ifmap_fwd_r;
    assign bus.weight_o    = weight_fwd_r;
    assign bus.ifmap_v_o   = fwd_v_r;
    assign bus.weight_v_o  = fwd_v_r;
    assign bus.out_o       = out_r;
    assign bus.out_valid_o = out_valid_r;
    assign bus.psum_o      = acc_r;
    assign bus.busy_o      = busy_r;
endmodule
